dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences the single-port data memory and shares it between two requesters: the core load/store path and an external port used for debug, DMA or program loading.
- Serialises accesses, stalls the core while it waits, and returns read data and done pulses to whichever requester owns the transaction.
- Sits between the core datapath and the data memory macro in the processor top.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- core_req  in  1  core access request; held until core_done.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  store data.
- core_rdata  out  DATA_W  load data; valid while core_done=1.
- core_done  out  1  one-cycle completion pulse.
- core_stall  out  1  equals core_req & ~core_done; freezes the PC and pipeline regs.
- ext_req  in  1  external request; held until ext_done.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  one-cycle pulse in the accept cycle.
- ext_rdata  out  DATA_W  read data; valid while ext_done=1.
- ext_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  2  00 idle, 01 core, 10 ext.

Behaviour:
- FSM states:
  - IDLE: arbitrate. On any request go to ISSUE and latch owner, we, addr and wdata.
  - ISSUE: mem_en=1 with the latched fields, for one cycle. Next state: write → RESP; read with RD_LAT=1 → RESP; read with RD_LAT>1 → WAIT.
  - WAIT: down-counter loaded with RD_LAT-1 on leaving ISSUE; go to RESP when it reaches 1.
  - RESP: owner's done pulse; for reads, rdata = mem_rdata passed through combinationally. Next state is IDLE.
- Latency, counted from the request seen in IDLE at cycle 0:
  - mem_en at cycle 1.
  - Write done at cycle 2.
  - Read done at cycle 1+RD_LAT.
  - Next accept earliest in the cycle after RESP.
- Arbitration (default): fixed priority; core wins when both requests are high in IDLE. The ext requester may starve.
- Handshake:
  - Requester inputs are sampled only in the IDLE accept cycle; later changes are ignored.
  - A request dropped before done is a protocol violation; the transaction still completes and done still pulses.
  - The non-granted requester waits; its request is not lost.
- core_stall is combinational. It is 0 when core_req=0, and 0 during the core_done cycle so the core advances that cycle.
- core_rdata and ext_rdata are 0 when their done signal is low.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
- Reset: rst=0 at a clock edge forces IDLE, counter 0, last-owner flag core, and all outputs 0 (except core_stall, which follows core_req). This applies mid-transaction too: the in-flight access is dropped with no done pulse. Memory contents are not rolled back.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are high in IDLE, grant the one not granted last. When only one requests, it wins regardless. The last-owner flag updates on each accept and resets to core, so ext wins the first tie after reset.
- Undefined: fixed core priority, as in Behaviour.

Test Plan:
- Core load: core_req=1, we=0, addr=0x10, mem returns 0xDEADBEEF, RD_LAT=1 → mem_en at cycle 1 with mem_addr=0x10; core_done and core_rdata=0xDEADBEEF at cycle 2; core_stall=1 at cycles 0–1 and 0 at cycle 2.
- Ext write: ext_req=1, we=1, addr=0x24, wdata=0x12345678 → ext_gnt at cycle 0; mem_en=mem_we=1 with those values at cycle 1; ext_done at cycle 2; owner=10 during cycles 1–2.
- Simultaneous: core read 0x0 and ext read 0x4 both asserted at cycle 0 → core served first (done at cycle 2); ext accepted at cycle 3, done at cycle 5. With DMEM_ARB_RR_EN, ext is served first.
- RD_LAT=3 read: mem_en at cycle 1 → done at cycle 4 with mem_rdata from cycle 4; no second mem_en in between.
- Reset mid-read: rst=0 at cycle 2 of an RD_LAT=3 core read → no core_done; outputs 0 and owner=00 from cycle 3; with core_req still high, a new accept occurs in the first IDLE cycle after rst=1.
- Starvation check (RR build): both requesters held high for 12 cycles with RD_LAT=1 → grants alternate core/ext, giving 4 transactions, 2 per requester.

Source files
------------

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: sequences a single-port data memory shared by the core load/store path and an external port.
// Define DMEM_ARB_RR_EN for round-robin arbitration; the default is fixed core priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_done,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_EXT  = 2'b10;
    localparam int         CNT_W    = 3;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        own_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              grant_core;
    logic              grant_ext;
    logic              accept;

`ifdef DMEM_ARB_RR_EN
    // Set when the external port won the most recent accept.
    logic last_ext_q;

    always_ff @(posedge clk) begin
        if (!rst) last_ext_q <= 1'b0;
        else if (accept) last_ext_q <= grant_ext;
    end
`endif

    // Arbitration only happens in IDLE and never while reset is held.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
        grant_core = 1'b0;
        grant_ext  = 1'b0;
        if (state == S_IDLE && rst) begin
`ifdef DMEM_ARB_RR_EN
            if (core_req && ext_req) begin
                grant_core = last_ext_q;
                grant_ext  = ~last_ext_q;
            end else begin
                grant_core = core_req;
                grant_ext  = ext_req;
            end
`else
            grant_core = core_req;
            grant_ext  = ext_req & ~core_req;
`endif
        end
    end

    assign accept = grant_core | grant_ext;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-low.
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (!we_q && RD_LAT > 1) ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt_q == CNT_W'(1)) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transaction fields are captured once, in the accept cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            own_q   <= OWN_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                own_q   <= grant_core ? OWN_CORE : OWN_EXT;
                we_q    <= grant_core ? core_we : ext_we;
                addr_q  <= grant_core ? core_addr : ext_addr;
                wdata_q <= grant_core ? core_wdata : ext_wdata;
            end
            if (state == S_ISSUE)     cnt_q <= CNT_W'(RD_LAT - 1);
            else if (state == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Outputs decode from state and the latched fields.
    always_comb begin
        mem_en     = (state == S_ISSUE);
        mem_we     = mem_en & we_q;
        mem_addr   = mem_en ? addr_q : '0;
        mem_wdata  = mem_en ? wdata_q : '0;
        core_done  = (state == S_RESP) && (own_q == OWN_CORE);
        ext_done   = (state == S_RESP) && (own_q == OWN_EXT);
        core_rdata = (core_done && !we_q) ? mem_rdata : '0;
        ext_rdata  = (ext_done && !we_q) ? mem_rdata : '0;
        ext_gnt    = grant_ext;
        owner      = (state == S_IDLE) ? OWN_NONE : own_q;
        core_stall = core_req & ~core_done;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_arbiter: one instance with RD_LAT=1 (both ports), one with RD_LAT=3 (core port).
module tb_dmem_arbiter;

    localparam logic [1:0] CORE = 2'b01;
    localparam logic [1:0] EXT  = 2'b10;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        logic [1:0]  own;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        logic [1:0]  own;
        bit          chk;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst3;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    acc_t  mem_q1[$];
    acc_t  mem_q3[$];
    resp_t core_q1[$];
    resp_t ext_q1[$];
    resp_t core_q3[$];
    int    gnt_q1[$];

    // DUT1 (RD_LAT=1)
    logic        c1_req, c1_we, c1_done, c1_stall;
    logic [31:0] c1_addr, c1_wdata, c1_rdata;
    logic        e1_req, e1_we, e1_gnt, e1_done;
    logic [31:0] e1_addr, e1_wdata, e1_rdata;
    logic        m1_en, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [1:0]  own1;

    // DUT3 (RD_LAT=3)
    logic        c3_req, c3_we, c3_done, c3_stall;
    logic [31:0] c3_addr, c3_wdata, c3_rdata;
    logic        e3_req, e3_we, e3_gnt, e3_done;
    logic [31:0] e3_addr, e3_wdata, e3_rdata;
    logic        m3_en, m3_we;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic [1:0]  own3;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata),
        .core_rdata(c1_rdata), .core_done(c1_done), .core_stall(c1_stall),
        .ext_req(e1_req), .ext_we(e1_we), .ext_addr(e1_addr), .ext_wdata(e1_wdata),
        .ext_gnt(e1_gnt), .ext_rdata(e1_rdata), .ext_done(e1_done),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .owner(own1)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst3),
        .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wdata),
        .core_rdata(c3_rdata), .core_done(c3_done), .core_stall(c3_stall),
        .ext_req(e3_req), .ext_we(e3_we), .ext_addr(e3_addr), .ext_wdata(e3_wdata),
        .ext_gnt(e3_gnt), .ext_rdata(e3_rdata), .ext_done(e3_done),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata), .owner(own3)
    );

    // Memory models: read data is valid only in the cycle RD_LAT after mem_en, poison otherwise.
    logic [31:0] mem1 [0:63];
    logic [31:0] rd1;
    logic        rv1;
    always @(posedge clk) begin
        if (!rst) begin
            mem1[0] <= 32'hA0A0_A0A0;
            mem1[1] <= 32'h0B0B_0B0B;
            mem1[2] <= 32'hC0C0_C0C0;
            mem1[3] <= 32'hE0E0_E0E0;
            mem1[4] <= 32'hDEAD_BEEF;
            rv1     <= 1'b0;
        end else begin
            rv1 <= m1_en & ~m1_we;
            rd1 <= mem1[m1_addr[7:2]];
            if (m1_en && m1_we) mem1[m1_addr[7:2]] <= m1_wdata;
        end
    end
    assign m1_rdata = rv1 ? rd1 : 32'hBAD0_BAD0;

    logic [31:0] mem3 [0:63];
    logic [31:0] rd3 [0:2];
    logic [2:0]  rv3;
    always @(posedge clk) begin
        if (!rst) begin
            mem3[5] <= 32'h1357_9BDF;
            mem3[6] <= 32'h2468_ACE0;
            rv3     <= 3'b000;
        end else begin
            rv3[0] <= m3_en & ~m3_we;
            rd3[0] <= mem3[m3_addr[7:2]];
            for (int i = 1; i < 3; i++) begin
                rv3[i] <= rv3[i-1];
                rd3[i] <= rd3[i-1];
            end
        end
    end
    assign m3_rdata = rv3[2] ? rd3[2] : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input bit d3, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int c, input logic [1:0] own);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata; a.cyc = c; a.own = own;
        if (d3) mem_q3.push_back(a);
        else    mem_q1.push_back(a);
    endtask

    // which: 0 = DUT1 core, 1 = DUT1 ext, 2 = DUT3 core
    task automatic push_resp(input int which, input logic [31:0] data, input int c,
                             input logic [1:0] own, input bit chk);
        resp_t r;
        r.data = data; r.cyc = c; r.own = own; r.chk = chk;
        case (which)
            0:       core_q1.push_back(r);
            1:       ext_q1.push_back(r);
            default: core_q3.push_back(r);
        endcase
    endtask

    task automatic mon_mem(input bit d3, input logic en, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] own);
        acc_t  a;
        string tag = d3 ? "mem3" : "mem1";
        int    n   = d3 ? mem_q3.size() : mem_q1.size();
        if (en) begin
            check({tag, " access expected"}, 64'(n != 0), 64'(1));
            if (n != 0) begin
                a = d3 ? mem_q3.pop_front() : mem_q1.pop_front();
                check({tag, " cycle"}, 64'(cyc), 64'(a.cyc));
                check({tag, " we"}, 64'(we), 64'(a.we));
                check({tag, " addr"}, 64'(addr), 64'(a.addr));
                if (a.we) check({tag, " wdata"}, 64'(wdata), 64'(a.wdata));
                check({tag, " owner"}, 64'(own), 64'(a.own));
            end
        end else begin
            check({tag, " bus zero when idle"}, 64'(we || addr != 0 || wdata != 0), 64'(0));
        end
    endtask

    task automatic mon_resp(input int which, input logic done, input logic [31:0] rdata,
                            input logic [1:0] own, input logic stall);
        resp_t r;
        string tag = (which == 0) ? "core1" : (which == 1) ? "ext1" : "core3";
        int    n   = (which == 0) ? core_q1.size() : (which == 1) ? ext_q1.size() : core_q3.size();
        if (done) begin
            check({tag, " done expected"}, 64'(n != 0), 64'(1));
            if (n != 0) begin
                case (which)
                    0:       r = core_q1.pop_front();
                    1:       r = ext_q1.pop_front();
                    default: r = core_q3.pop_front();
                endcase
                check({tag, " done cycle"}, 64'(cyc), 64'(r.cyc));
                check({tag, " owner at done"}, 64'(own), 64'(r.own));
                if (r.chk) check({tag, " rdata"}, 64'(rdata), 64'(r.data));
                if (which != 1) check({tag, " stall at done"}, 64'(stall), 64'(0));
            end
        end else begin
            check({tag, " rdata zero without done"}, 64'(rdata), 64'(0));
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clk) begin
        mon_mem(1'b0, m1_en, m1_we, m1_addr, m1_wdata, own1);
        mon_mem(1'b1, m3_en, m3_we, m3_addr, m3_wdata, own3);
        mon_resp(0, c1_done, c1_rdata, own1, c1_stall);
        mon_resp(1, e1_done, e1_rdata, own1, 1'b0);
        mon_resp(2, c3_done, c3_rdata, own3, c3_stall);
        if (e1_gnt) begin
            check("ext1 gnt expected", 64'(gnt_q1.size() != 0), 64'(1));
            if (gnt_q1.size() != 0) check("ext1 gnt cycle", 64'(cyc), 64'(gnt_q1.pop_front()));
        end
        check("ext3 idle", 64'(e3_gnt || e3_done), 64'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int t0;
    int cd, ed;

    initial begin
        rst = 1'b0; rst3 = 1'b0;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        e1_req = 1'b1; e1_we = 1'b0; e1_addr = '0; e1_wdata = '0;
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        e3_req = 1'b0; e3_we = 1'b0; e3_addr = '0; e3_wdata = '0;

        // Reset state with both requests high: nothing accepted, stall follows core_req.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mem_en", 64'(m1_en), 64'(0));
        check("rst owner", 64'(own1), 64'(0));
        check("rst ext_gnt", 64'(e1_gnt), 64'(0));
        check("rst dones", 64'({c1_done, e1_done}), 64'(0));
        check("rst core_stall follows req", 64'(c1_stall), 64'(1));
        check("rst3 owner", 64'(own3), 64'(0));
        check("rst3 core_stall follows req", 64'(c3_stall), 64'(1));
        tick();
        c1_req = 1'b0; e1_req = 1'b0; c3_req = 1'b0;
        @(negedge clk);
        check("rst core_stall low without req", 64'(c1_stall), 64'(0));
        tick();
        rst = 1'b1; rst3 = 1'b1;
        tick(); tick();

        // Core load 0x10 -> 0xDEADBEEF, stall over cycles 0..2.
        tick(); t0 = cyc;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h10;
        push_mem(1'b0, 1'b0, 32'h10, 32'h0, t0 + 1, CORE);
        push_resp(0, 32'hDEAD_BEEF, t0 + 2, CORE, 1'b1);
        @(negedge clk); check("load stall c0", 64'(c1_stall), 64'(1));
        tick();
        @(negedge clk); check("load stall c1", 64'(c1_stall), 64'(1));
        tick();
        @(negedge clk); check("load stall c2", 64'(c1_stall), 64'(0));
        tick(); c1_req = 1'b0;

        // Ext write 0x24 <- 0x12345678.
        tick(); t0 = cyc;
        e1_req = 1'b1; e1_we = 1'b1; e1_addr = 32'h24; e1_wdata = 32'h1234_5678;
        gnt_q1.push_back(t0);
        push_mem(1'b0, 1'b1, 32'h24, 32'h1234_5678, t0 + 1, EXT);
        push_resp(1, 32'h0, t0 + 2, EXT, 1'b0);
        repeat (3) tick();
        e1_req = 1'b0; e1_we = 1'b0;

        // Core reads back the word the ext port wrote.
        tick(); t0 = cyc;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h24;
        push_mem(1'b0, 1'b0, 32'h24, 32'h0, t0 + 1, CORE);
        push_resp(0, 32'h1234_5678, t0 + 2, CORE, 1'b1);
        repeat (3) tick();
        c1_req = 1'b0;

        // Simultaneous core read 0x0 and ext read 0x4.
        tick(); t0 = cyc;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h0;
        e1_req = 1'b1; e1_we = 1'b0; e1_addr = 32'h4;
`ifdef DMEM_ARB_RR_EN
        cd = 5; ed = 2;
        gnt_q1.push_back(t0);
        push_mem(1'b0, 1'b0, 32'h4, 32'h0, t0 + 1, EXT);
        push_mem(1'b0, 1'b0, 32'h0, 32'h0, t0 + 4, CORE);
`else
        cd = 2; ed = 5;
        gnt_q1.push_back(t0 + 3);
        push_mem(1'b0, 1'b0, 32'h0, 32'h0, t0 + 1, CORE);
        push_mem(1'b0, 1'b0, 32'h4, 32'h0, t0 + 4, EXT);
`endif
        push_resp(0, 32'hA0A0_A0A0, t0 + cd, CORE, 1'b1);
        push_resp(1, 32'h0B0B_0B0B, t0 + ed, EXT, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (cyc == t0 + cd + 1) c1_req = 1'b0;
            if (cyc == t0 + ed + 1) e1_req = 1'b0;
        end

        // Request dropped after accept: still completes with the latched fields.
        tick(); t0 = cyc;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 32'h30; c1_wdata = 32'h55AA_55AA;
        push_mem(1'b0, 1'b1, 32'h30, 32'h55AA_55AA, t0 + 1, CORE);
        push_resp(0, 32'h0, t0 + 2, CORE, 1'b0);
        tick();
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = 32'h99; c1_wdata = 32'h0;
        tick(); tick();

        // Both held for 12 cycles: fixed priority starves ext, round-robin alternates ext/core.
        tick(); t0 = cyc;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h8;
        e1_req = 1'b1; e1_we = 1'b0; e1_addr = 32'hC;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            if (k % 2 == 0) begin
                gnt_q1.push_back(t0 + 3 * k);
                push_mem(1'b0, 1'b0, 32'hC, 32'h0, t0 + 3 * k + 1, EXT);
                push_resp(1, 32'hE0E0_E0E0, t0 + 3 * k + 2, EXT, 1'b1);
            end else begin
                push_mem(1'b0, 1'b0, 32'h8, 32'h0, t0 + 3 * k + 1, CORE);
                push_resp(0, 32'hC0C0_C0C0, t0 + 3 * k + 2, CORE, 1'b1);
            end
`else
            push_mem(1'b0, 1'b0, 32'h8, 32'h0, t0 + 3 * k + 1, CORE);
            push_resp(0, 32'hC0C0_C0C0, t0 + 3 * k + 2, CORE, 1'b1);
`endif
        end
        repeat (12) tick();
        c1_req = 1'b0; e1_req = 1'b0;

        // RD_LAT=3 core read 0x14: one mem_en, done at cycle 4.
        tick(); t0 = cyc;
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h14;
        push_mem(1'b1, 1'b0, 32'h14, 32'h0, t0 + 1, CORE);
        push_resp(2, 32'h1357_9BDF, t0 + 4, CORE, 1'b1);
        repeat (3) tick();
        @(negedge clk); check("lat3 stall c3", 64'(c3_stall), 64'(1));
        tick(); tick();
        c3_req = 1'b0;

        // Reset at cycle 2 of an RD_LAT=3 read: dropped, then re-accepted after release.
        tick(); t0 = cyc;
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h18;
        push_mem(1'b1, 1'b0, 32'h18, 32'h0, t0 + 1, CORE);
        tick(); tick();
        rst3 = 1'b0;
        tick();
        @(negedge clk);
        check("midrst owner", 64'(own3), 64'(0));
        check("midrst mem_en", 64'(m3_en), 64'(0));
        check("midrst core_done", 64'(c3_done), 64'(0));
        check("midrst stall follows req", 64'(c3_stall), 64'(1));
        tick();
        rst3 = 1'b1;
        push_mem(1'b1, 1'b0, 32'h18, 32'h0, t0 + 5, CORE);
        push_resp(2, 32'h2468_ACE0, t0 + 8, CORE, 1'b1);
        repeat (5) tick();
        c3_req = 1'b0;

        repeat (4) tick();
        check("mem1 queue drained", 64'(mem_q1.size()), 64'(0));
        check("mem3 queue drained", 64'(mem_q3.size()), 64'(0));
        check("core1 queue drained", 64'(core_q1.size()), 64'(0));
        check("ext1 queue drained", 64'(ext_q1.size()), 64'(0));
        check("core3 queue drained", 64'(core_q3.size()), 64'(0));
        check("gnt1 queue drained", 64'(gnt_q1.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
